// File: rtl/fpadd_ctrl_pkg.sv
// Shared types and helpers for the fpadd sharing scheduler.
package fpadd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/fpadd_tag_pipe.sv
// Tag shift register that follows each operand pair through the adder so the
// result can be routed back to the requester that issued it.
module fpadd_tag_pipe
  import fpadd_ctrl_pkg::*;
#(
  parameter int LAT  = 3,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_valid,
  input  logic [ID_W-1:0] load_id,
  output logic            last_valid,
  output logic [ID_W-1:0] last_id,
  output logic            any_valid,
  output logic            upstream_empty
);

  logic [LAT-1:0]  valid_q;
  logic [ID_W-1:0] id_q [LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int s = 0; s < LAT; s++) id_q[s] <= '0;
    end else begin
      valid_q[0] <= load_valid;
      id_q[0]    <= load_id;
      for (int s = 1; s < LAT; s++) begin
        valid_q[s] <= valid_q[s-1];
        id_q[s]    <= id_q[s-1];
      end
    end
  end

  assign last_valid = valid_q[LAT-1];
  assign last_id    = id_q[LAT-1];
  assign any_valid  = |valid_q;

  // True when only the final stage can hold a tag, i.e. the pipe empties on the next edge.
  always_comb begin
    upstream_empty = 1'b1;
    for (int s = 0; s < LAT - 1; s++) begin
      if (valid_q[s]) upstream_empty = 1'b0;
    end
  end

endmodule

// File: rtl/fpadd_rr_sched.sv
// Round-robin scheduler sharing one pipelined FP adder between N_REQ requesters;
// results are routed back by a tag pipe matched to the adder latency.
module fpadd_rr_sched
  import fpadd_ctrl_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int LAT    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic                    add_valid,
  output logic [DATA_W-1:0]       add_a,
  output logic [DATA_W-1:0]       add_b,
  input  logic [DATA_W-1:0]       add_result,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy
);

  localparam int ID_W = clog2(N_REQ);

  state_t          state, state_next;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] grant_id;
  logic            grant;
  logic            last_valid;
  logic [ID_W-1:0] last_id;
  logic            any_valid;
  logic            upstream_empty;
  int              idx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A grant in the cycle enable falls still lands in the pipe, so count it as in flight.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = (any_valid || grant) ? DRAIN : IDLE;
      DRAIN: begin
        if (enable)              state_next = RUN;
        else if (upstream_empty) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant    = 1'b0;
    grant_id = '0;
    idx      = 0;
    if (state == RUN && !reset) begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx = (int'(ptr) + k) % N_REQ;
        if (!grant && req_valid[ID_W'(idx)]) begin
          grant    = 1'b1;
          grant_id = ID_W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)      ptr <= ID_W'(N_REQ - 1);
    else if (grant) ptr <= grant_id;
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_id] = 1'b1;
  end

  assign add_valid = grant;
  assign add_a     = grant ? req_a[int'(grant_id)*DATA_W +: DATA_W] : '0;
  assign add_b     = grant ? req_b[int'(grant_id)*DATA_W +: DATA_W] : '0;

  fpadd_tag_pipe #(
    .LAT  (LAT),
    .ID_W (ID_W)
  ) u_tag_pipe (
    .clk            (clk),
    .reset          (reset),
    .load_valid     (grant),
    .load_id        (grant_id),
    .last_valid     (last_valid),
    .last_id        (last_id),
    .any_valid      (any_valid),
    .upstream_empty (upstream_empty)
  );

  always_comb begin
    rsp_valid = '0;
    if (last_valid && !reset) rsp_valid[last_id] = 1'b1;
  end

  assign rsp_data = add_result;
  assign busy     = any_valid && !reset;

endmodule

// File: tb/tb_fpadd_rr_sched.sv
// Bench for fpadd_rr_sched: a transaction-level model of arbitration and result
// routing checked every cycle, plus directed scenarios with literal expectations.
module tb_fpadd_rr_sched;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 3;

  logic           clk = 1'b0;
  logic           reset, enable;
  logic [N-1:0]   req_valid, req_ready, rsp_valid;
  logic [N*W-1:0] req_a, req_b;
  logic           add_valid, busy;
  logic [W-1:0]   add_a, add_b, add_result, rsp_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpadd_rr_sched #(.N_REQ(N), .DATA_W(W), .LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .add_valid  (add_valid),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  // Simple single-precision add for positive normal operands, truncating.
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] hi, lo;
    logic [7:0]  e, d;
    logic [23:0] mh, ml;
    logic [24:0] s;
    if (x[30:23] >= y[30:23]) begin hi = x; lo = y; end
    else begin hi = y; lo = x; end
    e  = hi[30:23];
    d  = e - lo[30:23];
    mh = {1'b1, hi[22:0]};
    ml = (d > 8'd23) ? 24'd0 : ({1'b1, lo[22:0]} >> d);
    s  = {1'b0, mh} + {1'b0, ml};
    if (s[24]) begin
      s = s >> 1;
      e = e + 8'd1;
    end
    return {1'b0, e, s[22:0]};
  endfunction

  // Stand-in for the fpadd core with the same fixed latency.
  logic [31:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= add_valid ? fadd(add_a, add_b) : 32'h0;
    for (int s = 1; s < LAT; s++) apipe[s] <= apipe[s-1];
  end
  assign add_result = apipe[LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic [N-1:0] v);
    @(posedge clk);
    #1;
    reset     = rst;
    enable    = en;
    req_valid = v;
  endtask

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } rsp_t;

  rsp_t        pend[$];
  int          cyc   = 0;
  int          ptr_m = N - 1;
  logic        run_m = 1'b0;
  int          exp_id;
  logic [N-1:0] exp_ready, exp_rsp;
  logic [31:0] exp_a, exp_b;

  // Model: arbitration is enabled when enable was high at the previous edge
  // outside reset; every grant comes back LAT cycles later to the same requester.
  always begin
    @(negedge clk);
    exp_id = -1;
    if (!reset && run_m) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (ptr_m + k) % N;
        if (exp_id < 0 && req_valid[j]) exp_id = j;
      end
    end
    exp_ready = '0;
    exp_a     = '0;
    exp_b     = '0;
    if (exp_id >= 0) begin
      exp_ready[exp_id] = 1'b1;
      exp_a = req_a[exp_id*W +: W];
      exp_b = req_b[exp_id*W +: W];
    end
    checkOutput("model req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("model add_valid", 32'(add_valid), 32'(exp_id >= 0));
    checkOutput("model add_a", add_a, exp_a);
    checkOutput("model add_b", add_b, exp_b);
    exp_rsp = '0;
    if (!reset && pend.size() > 0 && pend[0].due == cyc) exp_rsp[pend[0].id] = 1'b1;
    checkOutput("model rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (exp_rsp != '0) checkOutput("model rsp_data", rsp_data, pend[0].data);
    checkOutput("model busy", 32'(busy), 32'(!reset && pend.size() > 0));
    @(posedge clk);
    if (reset) begin
      pend.delete();
      run_m = 1'b0;
      ptr_m = N - 1;
    end else begin
      if (exp_id >= 0) begin
        pend.push_back('{cyc + LAT, exp_id, fadd(exp_a, exp_b)});
        ptr_m = exp_id;
      end
      run_m = enable;
    end
    cyc++;
    while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
  end

  logic [31:0] res_tab [N];

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    req_valid = '0;
    req_a     = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    req_b     = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000};
    res_tab[0] = 32'h40400000;
    res_tab[1] = 32'h40400000;
    res_tab[2] = 32'h40800000;
    res_tab[3] = 32'h40A00000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req_ready", 32'(req_ready), 32'h0);
    checkOutput("reset add_valid", 32'(add_valid), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);

    // Single operation with latency 3
    applyStimulus(1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    @(negedge clk);
    checkOutput("idle no grant", 32'(req_ready), 32'h0);
    applyStimulus(1'b0, 1'b1, 4'b0001);
    @(negedge clk);
    checkOutput("single grant", 32'(req_ready), 32'h1);
    checkOutput("single add_a", add_a, 32'h3F800000);
    checkOutput("single add_b", add_b, 32'h40000000);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    @(negedge clk);
    checkOutput("single rsp early1", 32'(rsp_valid), 32'h0);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    @(negedge clk);
    checkOutput("single rsp early2", 32'(rsp_valid), 32'h0);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    @(negedge clk);
    checkOutput("single rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("single rsp_data", rsp_data, 32'h40400000);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    @(negedge clk);
    checkOutput("single busy after", 32'(busy), 32'h0);

    // All requesters valid from reset: rotation 0,1,2,3,... with no gaps
    applyStimulus(1'b1, 1'b1, 4'b1111);
    applyStimulus(1'b1, 1'b1, 4'b1111);
    applyStimulus(1'b0, 1'b1, 4'b1111);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 4'b1111);
      @(negedge clk);
      checkOutput("rr grant", 32'(req_ready), 32'(1) << (i % N));
      if (i >= LAT) begin
        checkOutput("rr rsp_valid", 32'(rsp_valid), 32'(1) << ((i - LAT) % N));
        checkOutput("rr rsp_data", rsp_data, res_tab[(i - LAT) % N]);
      end
    end
    repeat (6) applyStimulus(1'b0, 1'b0, 4'b0000);

    // Enable dropped after two issues: drain then idle, no grants meanwhile
    applyStimulus(1'b0, 1'b1, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b0010);
    @(negedge clk);
    checkOutput("drain grant1", 32'(req_ready), 32'h2);
    applyStimulus(1'b0, 1'b1, 4'b0010);
    @(negedge clk);
    checkOutput("drain grant2", 32'(req_ready), 32'h2);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    checkOutput("drain busy0", 32'(busy), 32'h1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 4'b0010);
      @(negedge clk);
      checkOutput("drain busy", 32'(busy), 32'h1);
      checkOutput("drain rsp_valid", 32'(rsp_valid), 32'h2);
      checkOutput("drain no ready", 32'(req_ready), 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 4'b0010);
    @(negedge clk);
    checkOutput("drain idle busy", 32'(busy), 32'h0);
    checkOutput("drain idle ready", 32'(req_ready), 32'h0);
    applyStimulus(1'b0, 1'b0, 4'b0000);

    // Reset with three operations in flight
    applyStimulus(1'b0, 1'b1, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b0101);
    @(negedge clk);
    checkOutput("inflight grant a", 32'(req_ready), 32'h4);
    applyStimulus(1'b0, 1'b1, 4'b0101);
    @(negedge clk);
    checkOutput("inflight grant b", 32'(req_ready), 32'h1);
    applyStimulus(1'b0, 1'b1, 4'b0101);
    @(negedge clk);
    checkOutput("inflight grant c", 32'(req_ready), 32'h4);
    applyStimulus(1'b1, 1'b1, 4'b0101);
    @(negedge clk);
    checkOutput("in reset busy", 32'(busy), 32'h0);
    checkOutput("in reset rsp", 32'(rsp_valid), 32'h0);
    checkOutput("in reset ready", 32'(req_ready), 32'h0);
    applyStimulus(1'b0, 1'b1, 4'b0101);
    @(negedge clk);
    checkOutput("post reset busy", 32'(busy), 32'h0);
    checkOutput("post reset rsp", 32'(rsp_valid), 32'h0);
    applyStimulus(1'b0, 1'b1, 4'b0101);
    @(negedge clk);
    checkOutput("post reset grant", 32'(req_ready), 32'h1);
    checkOutput("post reset stale rsp", 32'(rsp_valid), 32'h0);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    @(negedge clk);
    checkOutput("post reset rsp0", 32'(rsp_valid), 32'h1);

    // Lone requester wraps around to itself; dropped request leaves pointer alone
    applyStimulus(1'b0, 1'b1, 4'b0100);
    @(negedge clk);
    checkOutput("wrap grant1", 32'(req_ready), 32'h4);
    applyStimulus(1'b0, 1'b1, 4'b0100);
    @(negedge clk);
    checkOutput("wrap grant2", 32'(req_ready), 32'h4);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b0001);
    @(negedge clk);
    checkOutput("dropped no grant", 32'(req_ready), 32'h0);
    repeat (5) applyStimulus(1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b0011);
    @(negedge clk);
    checkOutput("ptr kept grant", 32'(req_ready), 32'h1);
    repeat (6) applyStimulus(1'b0, 1'b0, 4'b0000);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
